// File: rtl/dpi_call_serializer_if.sv
// Bundle of request/response and shared call-port signals for dpi_call_serializer.
// The slave side is the serializer itself; the master side holds the call
// sites and the foreign-call executor.
interface dpi_call_serializer_if #(
    parameter int NREQ  = 4,
    parameter int ARG_W = 32,
    parameter int RES_W = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ARG_W-1:0] req_arg;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [RES_W-1:0]      rsp_data;
    logic                  call_start;
    logic [ARG_W-1:0]      call_arg;
    logic                  call_done;
    logic [RES_W-1:0]      call_result;

    modport slave (
        input  req_valid, req_arg, call_done, call_result,
        output req_ready, rsp_valid, rsp_data, call_start, call_arg
    );

    modport master (
        output req_valid, req_arg, call_done, call_result,
        input  req_ready, rsp_valid, rsp_data, call_start, call_arg
    );
endinterface

// File: rtl/dpi_call_serializer.sv
// Round-robin serializer sharing one non-reentrant foreign-call port between
// NREQ requesters. Only one call is ever in flight; the result goes back to
// the requester that issued it. Completions arriving outside WAIT are counted
// as spurious, and a call that never completes is aborted after TIMEOUT
// WAIT cycles with an all-ones result and a sticky error flag.
module dpi_call_serializer #(
    parameter int NREQ    = 4,
    parameter int ARG_W   = 32,
    parameter int RES_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dpi_call_serializer_if.slave bus,
    output logic                 busy,
    output logic [7:0]           spurious_cnt,
    output logic                 timeout_err
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] winner;
    logic [ID_W:0]   idx_wide;
    logic            win_found;
    logic [ARG_W-1:0] win_arg;
    logic [ARG_W-1:0] arg_q;
    logic [RES_W-1:0] result_q;
    logic [15:0]     wait_cnt;
    logic            wait_expired;
    logic            accept;

    assign wait_expired = (wait_cnt == 16'(TIMEOUT - 1));
    assign accept       = (state == IDLE) && win_found;
    assign busy         = (state != IDLE);
    assign bus.call_arg = arg_q;
    assign bus.rsp_data = result_q;

    // Round-robin search for the first valid requester starting at ptr.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        idx_wide  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_wide = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx_wide >= (ID_W + 1)'(NREQ)) begin
                idx_wide = idx_wide - (ID_W + 1)'(NREQ);
            end
            if (!win_found && bus.req_valid[idx_wide[ID_W-1:0]]) begin
                win_found = 1'b1;
                winner    = idx_wide[ID_W-1:0];
            end
        end
    end

    // Select the winner's argument slice with constant part-selects.
    always_comb begin
        win_arg = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_arg = bus.req_arg[i*ARG_W +: ARG_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe outputs; ready is held low while reset is asserted.
    always_comb begin
        state_next     = state;
        bus.req_ready  = '0;
        bus.rsp_valid  = '0;
        bus.call_start = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && rst_n) begin
                    bus.req_ready[winner] = 1'b1;
                    state_next            = ISSUE;
                end
            end
            ISSUE: begin
                bus.call_start = 1'b1;
                state_next     = WAIT;
            end
            WAIT: begin
                if (bus.call_done || wait_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[id] = 1'b1;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the granted requester and its argument at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id    <= '0;
            arg_q <= '0;
        end else if (accept) begin
            id    <= winner;
            arg_q <= win_arg;
        end
    end

    // Move the round-robin pointer past the requester just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == RESP) begin
            ptr <= (id == ID_W'(NREQ - 1)) ? '0 : id + ID_W'(1);
        end
    end

    // Count WAIT cycles; cleared whenever not waiting so each call starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Latch the call result, or all-ones on timeout; completion wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else if (state == WAIT) begin
            if (bus.call_done) begin
                result_q <= bus.call_result;
            end else if (wait_expired) begin
                result_q <= '1;
            end
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if ((state == WAIT) && !bus.call_done && wait_expired) begin
            timeout_err <= 1'b1;
        end
    end

    // Saturating count of completions seen outside WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spurious_cnt <= '0;
        end else if (bus.call_done && (state != WAIT) && (spurious_cnt != 8'hFF)) begin
            spurious_cnt <= spurious_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_dpi_call_serializer.sv
// Self-checking bench for dpi_call_serializer: directed scenarios followed by
// randomized calls, all compared against a transaction-level reference model.
module tb_dpi_call_serializer;
    localparam int NREQ    = 4;
    localparam int ARG_W   = 32;
    localparam int RES_W   = 32;
    localparam int TIMEOUT = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       busy;
    logic [7:0] spurious_cnt;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int m_ptr   = 0;
    int m_spur  = 0;
    logic m_terr = 1'b0;
    int m_calls = 0;
    int m_resps = 0;

    // Monitor state.
    int   cyc_cnt     = 0;
    int   start_cnt   = 0;
    int   rsp_cnt     = 0;
    int   overlap_cnt = 0;
    logic outstanding = 1'b0;

    dpi_call_serializer_if #(.NREQ(NREQ), .ARG_W(ARG_W), .RES_W(RES_W)) bus ();

    dpi_call_serializer #(
        .NREQ(NREQ), .ARG_W(ARG_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .spurious_cnt(spurious_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Watch call launches and responses; flag a launch while a call is outstanding.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
        end else begin
            if (bus.call_start) begin
                if (outstanding) overlap_cnt <= overlap_cnt + 1;
                start_cnt <= start_cnt + 1;
            end
            if (bus.rsp_valid != '0) begin
                rsp_cnt <= rsp_cnt + 1;
            end
            if (bus.call_start) outstanding <= 1'b1;
            else if (bus.rsp_valid != '0) outstanding <= 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0 && i < NREQ) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // First requester with valid set, scanning from the model pointer with wrap.
    function automatic int model_winner(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One full call: offer requests in IDLE, then answer on WAIT cycle done_at
    // (values past TIMEOUT mean never answer), optionally with a spurious
    // completion during ISSUE, and check the response against the model.
    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int done_at,
                                 input logic [RES_W-1:0] res, input bit spur_issue,
                                 input bit fixed_en, input logic [ARG_W-1:0] fixed_arg,
                                 input string tag);
        logic [ARG_W-1:0] args [NREQ];
        int               win;
        int               lat;
        int               exp_lat;
        bit               answered;
        logic [RES_W-1:0] exp_data;
        for (int i = 0; i < NREQ; i++) begin
            args[i] = (fixed_en && mask[i]) ? fixed_arg : ARG_W'($urandom);
            bus.req_arg[i*ARG_W +: ARG_W] = args[i];
        end
        bus.req_valid = mask;
        #1;
        win = model_winner(mask);
        checkOutput({tag, "_idle_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_ready"}, 64'(bus.req_ready), 64'(onehot(win)));
        if (win < 0) begin
            step();
            return;
        end
        m_calls++;
        step();
        if (spur_issue) begin
            bus.call_done   = 1'b1;
            bus.call_result = ~res;
            m_spur = sat_inc(m_spur);
        end
        #1;
        checkOutput({tag, "_call_start"}, 64'(bus.call_start), 64'(1));
        checkOutput({tag, "_call_arg"}, 64'(bus.call_arg), 64'(args[win]));
        checkOutput({tag, "_ready_busy"}, 64'(bus.req_ready), 64'(0));
        step();
        bus.call_done = 1'b0;
        lat = 2;
        while (bus.rsp_valid == '0 && lat < 2 + TIMEOUT + 3) begin
            bus.call_done   = (lat - 1 == done_at);
            bus.call_result = res;
            step();
            bus.call_done = 1'b0;
            lat++;
        end
        answered = (done_at >= 1 && done_at <= TIMEOUT);
        exp_lat  = answered ? 2 + done_at : 2 + TIMEOUT;
        exp_data = answered ? res : '1;
        if (!answered) m_terr = 1'b1;
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(onehot(win)));
        checkOutput({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(exp_data));
        checkOutput({tag, "_timeout_err"}, 64'(timeout_err), 64'(m_terr));
        checkOutput({tag, "_spurious"}, 64'(spurious_cnt), 64'(m_spur));
        m_ptr = (win + 1) % NREQ;
        m_resps++;
        bus.req_valid = '0;
        step();
    endtask

    // Completion pulses while idle, each followed by a quiet cycle.
    task automatic idle_pulses(input int n);
        bus.req_valid = '0;
        for (int i = 0; i < n; i++) begin
            bus.call_done   = 1'b1;
            bus.call_result = RES_W'($urandom);
            step();
            bus.call_done = 1'b0;
            m_spur = sat_inc(m_spur);
            step();
        end
    endtask

    initial begin
        int c0;
        int r0;
        int s0;
        logic [NREQ-1:0] mask;

        bus.req_valid   = '0;
        bus.req_arg     = '0;
        bus.call_done   = 1'b0;
        bus.call_result = '0;

        // Reset with all requesters asserting valid: everything must read zero.
        #2;
        rst_n = 1'b0;
        bus.req_valid = '1;
        #1;
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_ready", 64'(bus.req_ready), 64'(0));
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        checkOutput("rst_call_start", 64'(bus.call_start), 64'(0));
        checkOutput("rst_call_arg", 64'(bus.call_arg), 64'(0));
        checkOutput("rst_spurious", 64'(spurious_cnt), 64'(0));
        checkOutput("rst_timeout_err", 64'(timeout_err), 64'(0));
        step();
        step();
        bus.req_valid = '0;
        rst_n = 1'b1;

        // Fairness: everyone valid, completion on the second WAIT cycle.
        c0 = cyc_cnt;
        r0 = rsp_cnt;
        for (int n = 0; n < 8; n++) begin
            applyStimulus(4'hF, 2, RES_W'($urandom), 1'b0, 1'b0, '0, "fair");
        end
        checkOutput("fair_rsp_count", 64'(rsp_cnt - r0), 64'(8));
        checkOutput("fair_cycles", 64'(cyc_cnt - c0), 64'(40));
        checkOutput("fair_spurious", 64'(spurious_cnt), 64'(0));

        // Single request from requester 2.
        s0 = start_cnt;
        applyStimulus(4'b0100, 1, 32'hBEEF, 1'b0, 1'b1, 32'h1234, "single");
        checkOutput("single_start_count", 64'(start_cnt - s0), 64'(1));

        // Completion on the last allowed WAIT cycle still returns the real result.
        applyStimulus(4'b0001, TIMEOUT, 32'hCAFE_0001, 1'b0, 1'b0, '0, "bound");

        // Spurious completions: three while idle, one alongside call_start.
        idle_pulses(3);
        applyStimulus(4'b1000, 2, 32'h5A5A_1234, 1'b1, 1'b0, '0, "spur");
        checkOutput("spur_total", 64'(spurious_cnt), 64'(4));

        // Timeout: no completion at all.
        applyStimulus(4'b0010, TIMEOUT + 1, 32'h0, 1'b0, 1'b0, '0, "tmo");
        step();
        step();
        checkOutput("tmo_sticky", 64'(timeout_err), 64'(1));

        // Randomized calls with occasional idle and issue-cycle spurious pulses.
        for (int n = 0; n < 24; n++) begin
            mask = NREQ'($urandom_range(15, 1));
            applyStimulus(mask, int'($urandom_range(TIMEOUT + 1, 1)), RES_W'($urandom),
                          ($urandom_range(3, 0) == 0), 1'b0, '0, "rand");
            idle_pulses(int'($urandom_range(2, 0)));
        end

        // Spurious counter saturates.
        idle_pulses(260);
        checkOutput("spur_saturate", 64'(spurious_cnt), 64'(255));

        // Reset while a call is in WAIT.
        bus.req_valid = 4'b0100;
        step();
        m_calls++;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_ready", 64'(bus.req_ready), 64'(0));
        checkOutput("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("midrst_rsp_data", 64'(bus.rsp_data), 64'(0));
        checkOutput("midrst_call_start", 64'(bus.call_start), 64'(0));
        checkOutput("midrst_call_arg", 64'(bus.call_arg), 64'(0));
        checkOutput("midrst_spurious", 64'(spurious_cnt), 64'(0));
        checkOutput("midrst_timeout_err", 64'(timeout_err), 64'(0));
        step();
        bus.req_valid = '0;
        #3;
        rst_n = 1'b1;
        m_ptr  = 0;
        m_spur = 0;
        m_terr = 1'b0;
        step();
        r0 = rsp_cnt;
        bus.call_done   = 1'b1;
        bus.call_result = 32'h1357_9BDF;
        step();
        bus.call_done = 1'b0;
        m_spur = sat_inc(m_spur);
        step();
        step();
        step();
        checkOutput("late_done_spurious", 64'(spurious_cnt), 64'(1));
        checkOutput("late_done_no_rsp", 64'(rsp_cnt - r0), 64'(0));
        checkOutput("late_done_idle", 64'(busy), 64'(0));
        applyStimulus(4'hF, 1, 32'h2468_ACE0, 1'b0, 1'b0, '0, "post_rst");

        // Global bookkeeping.
        checkOutput("no_overlap", 64'(overlap_cnt), 64'(0));
        checkOutput("start_count", 64'(start_cnt), 64'(m_calls));
        checkOutput("rsp_count", 64'(rsp_cnt), 64'(m_resps));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
